// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and constants for the result broadcast path.
// Contents:
//   writeback_packet_t  - result packet (valid flag, destination tag, result data)
//   CDB_PORTS, CDB_SRCS - number of broadcast ports and result sources
//   CDB_SRC_*           - source index constants used for grant/request vectors
package uarch_pkg;

   localparam int unsigned CDB_PORTS = 2;
   localparam int unsigned CDB_SRCS  = 4;
   localparam int unsigned TAG_W     = 6;
   localparam int unsigned DATA_W    = 32;

   localparam logic [1:0] CDB_SRC_ALU0   = 2'd0;
   localparam logic [1:0] CDB_SRC_ALU1   = 2'd1;
   localparam logic [1:0] CDB_SRC_MDU    = 2'd2;
   localparam logic [1:0] CDB_SRC_DCACHE = 2'd3;

   typedef struct packed {
      logic              is_valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } writeback_packet_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result/grant handshake and broadcast bundle between execute and the CDB arbiter.
// Signals:
//   alu_result0/1, mdu_result, dcache_result - candidate results (master -> slave)
//   *_cdb_gnt                                - per-source grants  (slave -> master)
//   cdb_port0/1                              - registered broadcast (slave -> master)
interface cdb_arbiter_if;
   import uarch_pkg::*;

   writeback_packet_t alu_result0;
   writeback_packet_t alu_result1;
   writeback_packet_t mdu_result;
   writeback_packet_t dcache_result;
   logic              alu_cdb_gnt0;
   logic              alu_cdb_gnt1;
   logic              mdu_cdb_gnt;
   logic              dcache_cdb_gnt;
   writeback_packet_t cdb_port0;
   writeback_packet_t cdb_port1;

   modport master (
      output alu_result0, alu_result1, mdu_result, dcache_result,
      input  alu_cdb_gnt0, alu_cdb_gnt1, mdu_cdb_gnt, dcache_cdb_gnt,
      input  cdb_port0, cdb_port1
   );

   modport slave (
      input  alu_result0, alu_result1, mdu_result, dcache_result,
      output alu_cdb_gnt0, alu_cdb_gnt1, mdu_cdb_gnt, dcache_cdb_gnt,
      output cdb_port0, cdb_port1
   );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-winner picker over four requesters.
// Ports:
//   req      in  request vector, one bit per source index
//   ptr      in  priority pointer (first index scanned in round-robin mode)
//   win_a    out one-hot first winner (all-zero if none)
//   win_b    out one-hot second winner (all-zero if none)
//   ptr_next out pointer after this cycle: last winner + 1, or ptr when idle
// RR_ENABLE = 0 replaces the rotating scan with the fixed order 3, 2, 0, 1.
module rr_pick2
   import uarch_pkg::*;
#(
   parameter int unsigned RR_ENABLE = 1
) (
   input  logic [CDB_SRCS-1:0] req,
   input  logic [1:0]          ptr,
   output logic [CDB_SRCS-1:0] win_a,
   output logic [CDB_SRCS-1:0] win_b,
   output logic [1:0]          ptr_next
);

   function automatic logic [1:0] scan_idx(input logic [1:0] p, input logic [1:0] k);
      if (RR_ENABLE != 0) begin
         return p + k;  // wraps mod 4
      end
      case (k)
         2'd0:    return CDB_SRC_DCACHE;
         2'd1:    return CDB_SRC_MDU;
         2'd2:    return CDB_SRC_ALU0;
         default: return CDB_SRC_ALU1;
      endcase
   endfunction

   logic [1:0] idx;
   logic [1:0] last;
   logic       found_a;
   logic       found_b;

   always_comb begin
      win_a   = '0;
      win_b   = '0;
      found_a = 1'b0;
      found_b = 1'b0;
      last    = ptr;
      idx     = '0;
      for (int k = 0; k < CDB_SRCS; k++) begin
         idx = scan_idx(ptr, 2'(k));
         if (req[idx]) begin
            if (!found_a) begin
               win_a[idx] = 1'b1;
               found_a    = 1'b1;
               last       = idx;
            end else if (!found_b) begin
               win_b[idx] = 1'b1;
               found_b    = 1'b1;
               last       = idx;
            end
         end
      end
      ptr_next = found_a ? last + 2'd1 : ptr;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates four result sources (alu0, alu1, mdu, dcache) onto two broadcast ports.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  slave side of cdb_arbiter_if: results in, same-cycle grants out,
//        cdb_port0/1 registered one cycle after the grant
// RR_ENABLE = 1 rotates priority past the last winner; 0 uses dcache > mdu > alu0 > alu1.
module cdb_arbiter
   import uarch_pkg::*;
#(
   parameter int unsigned RR_ENABLE = 1
) (
   input logic          clk,
   input logic          rst,
   cdb_arbiter_if.slave bus
);

   writeback_packet_t     src [CDB_SRCS];
   logic [CDB_SRCS-1:0]   req;
   logic [CDB_SRCS-1:0]   win_a;
   logic [CDB_SRCS-1:0]   win_b;
   logic [CDB_SRCS-1:0]   gnt;
   logic [1:0]            ptr_q;
   logic [1:0]            ptr_next;
   writeback_packet_t     port0_d;
   writeback_packet_t     port1_d;
   writeback_packet_t     port0_q;
   writeback_packet_t     port1_q;

   assign src[CDB_SRC_ALU0]   = bus.alu_result0;
   assign src[CDB_SRC_ALU1]   = bus.alu_result1;
   assign src[CDB_SRC_MDU]    = bus.mdu_result;
   assign src[CDB_SRC_DCACHE] = bus.dcache_result;

   always_comb begin
      req = '0;
      for (int i = 0; i < CDB_SRCS; i++) begin
         req[i] = src[i].is_valid;
      end
   end

   rr_pick2 #(
      .RR_ENABLE (RR_ENABLE)
   ) u_pick (
      .req      (req),
      .ptr      (ptr_q),
      .win_a    (win_a),
      .win_b    (win_b),
      .ptr_next (ptr_next)
   );

   // Grants depend only on the incoming requests and the pointer register.
   assign gnt = rst ? '0 : (win_a | win_b);

   assign bus.alu_cdb_gnt0   = gnt[CDB_SRC_ALU0];
   assign bus.alu_cdb_gnt1   = gnt[CDB_SRC_ALU1];
   assign bus.mdu_cdb_gnt    = gnt[CDB_SRC_MDU];
   assign bus.dcache_cdb_gnt = gnt[CDB_SRC_DCACHE];

   // One-hot select; with no winner the all-zero packet carries is_valid = 0.
   always_comb begin
      port0_d = '0;
      port1_d = '0;
      for (int i = 0; i < CDB_SRCS; i++) begin
         if (win_a[i]) port0_d = src[i];
         if (win_b[i]) port1_d = src[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         port0_q <= '0;
         port1_q <= '0;
      end else begin
         ptr_q   <= ptr_next;
         port0_q <= port0_d;
         port1_q <= port1_d;
      end
   end

   assign bus.cdb_port0 = port0_q;
   assign bus.cdb_port1 = port1_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a driver computes expected grants and broadcasts
// from a list-scan reference model and queues them; a monitor checks the ports.
module tb_cdb_arbiter;
   import uarch_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cdb_arbiter_if bus_rr ();
   cdb_arbiter_if bus_fx ();

   cdb_arbiter #(.RR_ENABLE(1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
   cdb_arbiter #(.RR_ENABLE(0)) dut_fx (.clk(clk), .rst(rst), .bus(bus_fx));

   typedef struct {
      writeback_packet_t p0;
      writeback_packet_t p1;
   } exp_t;

   int                n_cmp = 0;
   int                n_bad = 0;
   writeback_packet_t pkt    [4];
   writeback_packet_t fx_pkt [4];
   int                seq    [4];
   int                waitc  [4];
   int                mptr;
   exp_t              exp_q[$];
   bit                mon_en = 1'b0;
   logic [3:0]        dut_g;
   logic [3:0]        fx_g;

   assign bus_rr.alu_result0   = pkt[0];
   assign bus_rr.alu_result1   = pkt[1];
   assign bus_rr.mdu_result    = pkt[2];
   assign bus_rr.dcache_result = pkt[3];
   assign bus_fx.alu_result0   = fx_pkt[0];
   assign bus_fx.alu_result1   = fx_pkt[1];
   assign bus_fx.mdu_result    = fx_pkt[2];
   assign bus_fx.dcache_result = fx_pkt[3];
   assign dut_g = {bus_rr.dcache_cdb_gnt, bus_rr.mdu_cdb_gnt,
                   bus_rr.alu_cdb_gnt1, bus_rr.alu_cdb_gnt0};
   assign fx_g  = {bus_fx.dcache_cdb_gnt, bus_fx.mdu_cdb_gnt,
                   bus_fx.alu_cdb_gnt1, bus_fx.alu_cdb_gnt0};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Tag encodes the source in its top bits and a per-source sequence number below.
   function automatic writeback_packet_t mk(input int s);
      writeback_packet_t p;
      p.is_valid = 1'b1;
      p.tag      = 6'(s * 16 + seq[s] % 16);
      p.data     = $urandom;
      seq[s]++;
      return p;
   endfunction

   // Reference: list valid sources in scan order from the pointer, first two win.
   task automatic cycle(output logic [3:0] g, output logic [3:0] eg);
      int   order[$];
      exp_t e;
      @(negedge clk);
      order = {};
      for (int k = 0; k < 4; k++) begin
         if (pkt[(mptr + k) % 4].is_valid) order.push_back((mptr + k) % 4);
      end
      eg   = '0;
      e.p0 = '0;
      e.p1 = '0;
      if (order.size() >= 1) begin
         eg[order[0]] = 1'b1;
         e.p0         = pkt[order[0]];
      end
      if (order.size() >= 2) begin
         eg[order[1]] = 1'b1;
         e.p1         = pkt[order[1]];
      end
      if (order.size() >= 2) mptr = (order[1] + 1) % 4;
      else if (order.size() == 1) mptr = (order[0] + 1) % 4;
      g = dut_g;
      chk("grant", 64'(g), 64'(eg));
      exp_q.push_back(e);
      for (int s = 0; s < 4; s++) begin
         if (g[s]) begin
            chk("rr_wait", {63'd0, waitc[s] <= 1}, 64'd1);
            waitc[s] = 0;
         end else if (pkt[s].is_valid) begin
            waitc[s]++;
         end else begin
            waitc[s] = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Granted or idle sources present a new packet with probability pct, else go idle.
   task automatic advance(input logic [3:0] g, input int pct);
      for (int s = 0; s < 4; s++) begin
         if (g[s] || !pkt[s].is_valid) begin
            if ($urandom_range(99) < pct) pkt[s] = mk(s);
            else pkt[s].is_valid = 1'b0;
         end
      end
   endtask

   // Monitor: one expectation per clock edge while enabled.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && !rst) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               if (e.p0.is_valid) chk("port0", 64'(bus_rr.cdb_port0), 64'(e.p0));
               else chk("port0_valid", 64'(bus_rr.cdb_port0.is_valid), 64'd0);
               if (e.p1.is_valid) chk("port1", 64'(bus_rr.cdb_port1), 64'(e.p1));
               else chk("port1_valid", 64'(bus_rr.cdb_port1.is_valid), 64'd0);
            end else if (bus_rr.cdb_port0.is_valid || bus_rr.cdb_port1.is_valid) begin
               chk("unexpected_bcast", 64'd1, 64'd0);
            end
         end
      end
   end

   initial begin
      logic [3:0]        g;
      logic [3:0]        eg;
      writeback_packet_t d;
      writeback_packet_t m;
      for (int s = 0; s < 4; s++) begin
         seq[s]   = 0;
         waitc[s] = 0;
      end
      for (int s = 0; s < 4; s++) pkt[s] = mk(s);
      for (int s = 0; s < 4; s++) fx_pkt[s] = mk(s);
      mptr = 0;

      // Reset with every source requesting.
      #1 rst = 1'b1;
      #11;
      chk("rst_gnt_rr", 64'(dut_g), 64'd0);
      chk("rst_gnt_fx", 64'(fx_g), 64'd0);
      chk("rst_p0_valid", 64'(bus_rr.cdb_port0.is_valid), 64'd0);
      chk("rst_p1_valid", 64'(bus_rr.cdb_port1.is_valid), 64'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // Full contention from ptr 0: alu0+alu1, then mdu+dcache.
      cycle(g, eg);
      chk("full_c1", 64'(g), 64'h3);
      pkt[0].is_valid = 1'b0;
      pkt[1].is_valid = 1'b0;
      cycle(g, eg);
      chk("full_c2", 64'(g), 64'hc);
      pkt[2].is_valid = 1'b0;
      pkt[3].is_valid = 1'b0;

      // Lone mdu for three cycles, new tag each time; leaves ptr at 3.
      pkt[2] = mk(2);
      for (int i = 0; i < 3; i++) begin
         cycle(g, eg);
         chk("single_mdu", 64'(g), 64'h4);
         pkt[2] = mk(2);
      end
      pkt[2].is_valid = 1'b0;

      // Wrap-around from ptr 3: dcache to port0, alu0 to port1.
      pkt[0] = mk(0);
      pkt[3] = mk(3);
      cycle(g, eg);
      chk("wrap", 64'(g), 64'h9);
      pkt[0].is_valid = 1'b0;
      pkt[3].is_valid = 1'b0;
      cycle(g, eg);
      chk("idle", 64'(g), 64'h0);

      // Fixed priority instance: dcache and mdu win, alus starve.
      for (int s = 0; s < 4; s++) fx_pkt[s] = mk(s);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("fx_gnt", 64'(fx_g), 64'hc);
         d = fx_pkt[3];
         m = fx_pkt[2];
         @(posedge clk);
         #1;
         chk("fx_port0", 64'(bus_fx.cdb_port0), 64'(d));
         chk("fx_port1", 64'(bus_fx.cdb_port1), 64'(m));
         fx_pkt[3] = mk(3);
         fx_pkt[2] = mk(2);
      end

      // Random stress with varying load.
      for (int i = 0; i < 10000; i++) begin
         cycle(g, eg);
         advance(g, 30 + (i / 500) % 4 * 20);
      end

      // Reset mid-operation: ports clear at once, held packets are re-presented.
      for (int s = 0; s < 4; s++) if (!pkt[s].is_valid) pkt[s] = mk(s);
      cycle(g, eg);
      advance(g, 100);
      #2;
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      chk("midrst_p0_valid", 64'(bus_rr.cdb_port0.is_valid), 64'd0);
      chk("midrst_p1_valid", 64'(bus_rr.cdb_port1.is_valid), 64'd0);
      chk("midrst_gnt", 64'(dut_g), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst  = 1'b0;
      mptr = 0;
      for (int s = 0; s < 4; s++) waitc[s] = 0;
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(g, eg);
         advance(g, 0);
      end

      // Drain and confirm every expectation was consumed.
      for (int i = 0; i < 3; i++) cycle(g, eg);
      @(posedge clk);
      #3;
      chk("drain", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the four functional-unit result sources (ALU0, ALU1, MDU, D-cache load) onto the two common data bus ports. It returns a per-source grant in the same cycle a result is presented. Winners are registered onto `cdb_port0`/`cdb_port1` for the ROB, reservation stations and the execute-stage forwarding inputs. It is the responder side of the execute unit's result/grant handshake and sits between execute and writeback.

## Interface
Parameters:
- `RR_ENABLE`, default 1: 1 selects round-robin priority; 0 selects fixed priority dcache > mdu > alu0 > alu1.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `alu_result0`, `alu_result1`, `mdu_result`, `dcache_result`  in  `writeback_packet_t`  candidate results; a request exists when `.is_valid` = 1.
- `alu_cdb_gnt0`, `alu_cdb_gnt1`, `mdu_cdb_gnt`, `dcache_cdb_gnt`  out  1  grants, combinational from the current requests.
- `cdb_port0`, `cdb_port1`  out  `writeback_packet_t`  registered broadcast; `.is_valid` qualifies each port.

## Operation
- Source index: 0 = alu0, 1 = alu1, 2 = mdu, 3 = dcache.
- Handshake:
  - A source holds its packet stable with `.is_valid` = 1 until it samples its grant high at a rising edge.
  - That edge completes the transfer; the source may present a new packet in the next cycle.
  - Grant is never asserted for an invalid source.
- Selection per cycle:
  - Scan indices starting at the priority pointer `ptr` and wrapping mod 4.
  - The first valid source found is winner A; the second valid source is winner B.
  - At most 2 grants per cycle.
- Port mapping:
  - Winner A goes to `cdb_port0`, winner B to `cdb_port1`.
  - If there is only one winner, it goes to `cdb_port0` and `cdb_port1.is_valid` = 0.
- Pointer (`RR_ENABLE` = 1):
  - On a cycle with ≥1 grant, `ptr` ← (index of the last winner + 1) mod 4. The last winner is B if present, else A.
  - With no grants, `ptr` holds.
- `RR_ENABLE` = 0: the scan order is fixed at 3, 2, 0, 1 and `ptr` is unused.
- Fairness: with round-robin, any continuously valid source is granted within 2 cycles.
- Payload: the packet fields pass to the ports unmodified; there is no transformation.

## Timing
- Grant latency is 0 cycles (same cycle as valid). Broadcast latency is 1 cycle: the packet granted in cycle N appears on `cdb_port*` in cycle N+1 for exactly one cycle.
- A `cdb_port*` register with no winner loads a packet with `.is_valid` = 0. Stale data fields are don't-care, but `.is_valid` must be 0.
- Reset values:
  - `cdb_port0`, `cdb_port1` = all-zero packet.
  - `ptr` = 0.
  - While `rst` is high, all grants are forced to 0.
- Reset mid-operation:
  - Any packet granted in the same cycle `rst` asserts is dropped.
  - The ports clear asynchronously.
  - Sources re-present their packets after reset; no grant was seen at an edge, so no transfer occurred.
- Grants must not depend combinationally on `cdb_port*` or on any grant input path. There is no loop back to execute.

## Structure
- `uarch_pkg` owns:
  - `writeback_packet_t`, with `is_valid`, destination tag and result data.
  - `CDB_PORTS` = 2, `CDB_SRCS` = 4, and the `CDB_SRC_ALU0`/`ALU1`/`MDU`/`DCACHE` index constants.
- Sub-module `rr_pick2`:
  - Purely combinational.
  - Takes a 4-bit request vector and a 2-bit pointer.
  - Returns two one-hot winner vectors and a 2-bit next pointer.
- `cdb_arbiter` holds the pointer register, the port registers, and the source-to-vector packing.

## Test plan
- Reset: assert `rst` with all four sources valid → all grants 0, both port `.is_valid` = 0, `ptr` = 0. Release `rst` → grants appear on the first cycle.
- Full contention, RR:
  - Cycle 1: all four valid, `ptr` = 0 → grant alu0 and alu1. Next cycle `cdb_port0` = alu0, `cdb_port1` = alu1, `ptr` = 2.
  - Cycle 2: mdu and dcache still valid → grant both; they appear on port0/port1 the following cycle, `ptr` = 0.
- Wrap-around: `ptr` = 3 with alu0 and dcache valid → `cdb_port0` = dcache, `cdb_port1` = alu0, `ptr` becomes 1.
- Single requester: only mdu valid for 3 cycles, re-presenting a new tag each cycle → grant every cycle, each tag appears on `cdb_port0` once, `cdb_port1.is_valid` = 0.
- Fixed priority (`RR_ENABLE` = 0): all four valid for 2 cycles → both cycles grant dcache→port0 and mdu→port1; alu0 and alu1 are never granted.
- Random stress: random valid/hold traffic for 10k cycles → every packet is broadcast exactly once in order per source, no grant without valid, ≤2 grants per cycle, and RR wait ≤2 cycles.
